btn_cmd_arbiter: RTL and testbench
==================================

Name: btn_cmd_arbiter

Overview:
Shares a single command channel between N_BTN push-button inputs. Each raw button is synchronised and rising-edge detected, then latched as a pending request. Pending requests are granted round-robin onto a valid/ready command interface that feeds the lab datapath controller. One press produces exactly one command, regardless of how long the button is held.

Parameters:
N_BTN, 4, number of button requesters (2..16)
IDX_W, $clog2(N_BTN), width of the command index
DB_CYCLES, 16, debounce stability window in clk cycles (used only with the optional feature)

Ports:
clk      in   1      system clock
reset    in   1      asynchronous, active-high reset
btn_in   in   N_BTN  raw, asynchronous button levels, active-high
cmd_valid out 1      a command is offered
cmd_idx  out  IDX_W  index of the button being offered
cmd_ready in  1      consumer accepts the command in this cycle
pending  out  N_BTN  per-button outstanding-request flags
overrun  out  N_BTN  sticky per-button flag: a new press arrived while that button was already pending
ovr_clr  in   1      one-cycle pulse that clears all overrun bits
busy     out  1      OR of pending

Behaviour:
- Reset (async, active-high): all registers clear immediately on assertion.
  - Synchroniser flops, previous-level flops, pending, overrun, cmd_valid, cmd_idx, FSM all go to 0 / IDLE.
  - last_grant = N_BTN-1, so button 0 has first priority.
  - Reset asserted mid-handshake drops the command; no grant is recorded.
- Sync: btn_in[i] passes through 2 flops (s1, s2), then a previous-level flop s3. edge[i] = s2 & ~s3.
- Latency: btn_in[i] rises before edge t.
  - s1 = 1 at t, s2 = 1 at t+1, pending[i] = 1 at t+2.
  - cmd_valid = 1 at t+3 if the FSM is IDLE.
- Pending:
  - Set by edge[i].
  - Cleared on an accepted handshake (cmd_valid & cmd_ready) with cmd_idx == i.
  - If set and clear coincide, set wins and pending stays 1. The second press is therefore served later and overrun is not raised.
- Overrun:
  - overrun[i] is set when edge[i] & pending[i] and no clear of i occurs that cycle.
  - ovr_clr clears all bits. If set and ovr_clr coincide, set wins.
- FSM:
  - IDLE: if |pending, choose the first pending index scanning last_grant+1, +2, … modulo N_BTN. Register that index into cmd_idx, set cmd_valid = 1, go to OFFER. Otherwise stay in IDLE with cmd_valid = 0.
  - OFFER: cmd_valid and cmd_idx are held stable until cmd_ready. On cmd_ready, clear pending[cmd_idx], set last_grant = cmd_idx, drive cmd_valid = 0, go to IDLE.
  - Throughput is at most 1 command per 2 cycles.
  - cmd_ready while cmd_valid = 0 is ignored.
- Held button: only the first rising edge counts. Release followed by re-press produces a new edge.
- Index arithmetic: the round-robin wrap is explicit modulo N_BTN, so a non-power-of-two N_BTN never selects an out-of-range index.

Optional Feature:
Macro BTN_DEBOUNCE_EN.
- Defined: each channel gets a counter after s2. The filtered level updates only after s2 has differed from it for DB_CYCLES consecutive cycles; any bounce restarts the count. Edge detection uses the filtered level. Latency adds DB_CYCLES cycles.
- Undefined: no counters; edge detection uses s2 directly with the latency above.

Decomposition:
- Package btn_arb_pkg: state enum (IDLE, OFFER), default N_BTN and DB_CYCLES constants, and an rr_next function (next pending index from a mask and last_grant).
- Sub-module btn_chan: one per button, instantiated with generate. Contains the synchroniser, the optional debounce and the edge output. The arbiter top holds pending, overrun, FSM and round-robin state.

Test Plan:
- Reset, then btn_in = 0001 held for 10 cycles with cmd_ready = 1 → exactly one command: cmd_valid rises 3 cycles after the input edge, cmd_idx = 0. pending returns to 0000 and busy returns to 0.
- Buttons 0, 2 and 3 pressed in the same cycle, cmd_ready = 1 → commands in order idx 0, 2, 3, each valid for one cycle with one idle cycle between them.
- cmd_ready = 0 for 5 cycles while idx 1 is offered → cmd_valid and cmd_idx = 1 stay stable. Button 1 re-pressed during the stall → overrun[1] = 1. ovr_clr pulse → overrun = 0000.
- Button 2 re-press edge lands in the same cycle its handshake completes → pending[2] stays 1, a second idx 2 command follows, overrun[2] = 0.
- Reset asserted between edges while in OFFER → cmd_valid drops with no clock edge. After release, button 0 is granted before button 3.
- With BTN_DEBOUNCE_EN and DB_CYCLES = 16, a 1-0-1-0 bounce of 3 cycles each followed by a stable 1 → a single command, issued 16 + 3 cycles after the final rise.

Source files
------------

// File: rtl/btn_arb_pkg.sv
// Shared types and helpers for the button command arbiter.
// Round-robin search wraps explicitly modulo the button count.
package btn_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam int N_BTN_DEF     = 4;
  localparam int DB_CYCLES_DEF = 16;
  localparam int MAX_BTN       = 16;

  function automatic logic [3:0] rr_next(
    input logic [MAX_BTN-1:0] mask,
    input logic [3:0]         last,
    input int                 n
  );
    logic [3:0] idx;
    logic       found;
    rr_next = last;
    found   = 1'b0;
    for (int k = 1; k <= MAX_BTN; k++) begin
      if (k <= n) begin
        idx = 4'((int'(last) + k) % n);
        if (!found && mask[idx]) begin
          rr_next = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, optional debounce, rise pulse.
// BTN_DEBOUNCE_EN adds a DB_CYCLES stability filter after the synchroniser.
module btn_chan
`ifdef BTN_DEBOUNCE_EN
  #(parameter int DB_CYCLES = 16)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;
  logic lvl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          filt;

  // Any bounce back to the filtered level restarts the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (s2 == filt) begin
      cnt <= '0;
    end else if (cnt == CW'(DB_CYCLES - 1)) begin
      filt <= s2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign lvl = filt;
`else
  assign lvl = s2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) s3 <= 1'b0;
    else       s3 <= lvl;
  end

  assign rise = lvl & ~s3;

endmodule

// File: rtl/btn_cmd_arbiter.sv
// Round-robin arbiter turning button presses into valid/ready commands.
// Define BTN_DEBOUNCE_EN to add per-channel debounce filtering.
module btn_cmd_arbiter
  import btn_arb_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEF,
  parameter int IDX_W = $clog2(N_BTN)
`ifdef BTN_DEBOUNCE_EN
  ,
  parameter int DB_CYCLES = DB_CYCLES_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic             cmd_valid,
  output logic [IDX_W-1:0] cmd_idx,
  input  logic             cmd_ready,
  output logic [N_BTN-1:0] pending,
  output logic [N_BTN-1:0] overrun,
  input  logic             ovr_clr,
  output logic             busy
);

  logic [N_BTN-1:0] btn_edge;
  logic [N_BTN-1:0] clr;
  logic [N_BTN-1:0] ovr_set;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] lg_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [IDX_W-1:0] grant;
  logic             accept;
  state_t           state;
  state_t           state_nxt;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    btn_chan
`ifdef BTN_DEBOUNCE_EN
      #(.DB_CYCLES(DB_CYCLES))
`endif
    u_chan (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_in[gi]),
      .rise  (btn_edge[gi])
    );
  end

  assign cmd_valid = (state == OFFER);
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = |pending;
  assign grant     = IDX_W'(rr_next(MAX_BTN'(pending), 4'(last_grant), N_BTN));

  always_comb begin
    clr = '0;
    if (accept) clr[cmd_idx] = 1'b1;
  end

  // A fresh press on the granted button wins over the clear.
  assign ovr_set = btn_edge & pending & ~clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= (pending & ~clr) | btn_edge;
      overrun <= (ovr_clr ? '0 : overrun) | ovr_set;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = cmd_idx;
    lg_nxt    = last_grant;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          idx_nxt   = grant;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (cmd_ready) begin
          lg_nxt    = cmd_idx;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cmd_idx    <= '0;
      last_grant <= IDX_W'(N_BTN - 1);
    end else begin
      state      <= state_nxt;
      cmd_idx    <= idx_nxt;
      last_grant <= lg_nxt;
    end
  end

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// Self-checking bench for btn_cmd_arbiter (default N_BTN = 4).
// A negedge monitor pops expected indices at every accepted handshake.
module tb_btn_cmd_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] btn_in;
  logic       cmd_valid;
  logic [1:0] cmd_idx;
  logic       cmd_ready;
  logic [3:0] pending;
  logic [3:0] overrun;
  logic       ovr_clr;
  logic       busy;

  int checks = 0;
  int passed = 0;

  logic [1:0] exp_q[$];

  btn_cmd_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .cmd_valid (cmd_valid),
    .cmd_idx   (cmd_idx),
    .cmd_ready (cmd_ready),
    .pending   (pending),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always begin : mon
    logic [1:0] e;
    @(negedge clk);
    #2;
    if (!reset && cmd_valid && cmd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL handshake_unexpected: got idx %0d, expected none", cmd_idx);
      end else begin
        e = exp_q.pop_front();
        if (cmd_idx !== e)
          $display("FAIL handshake_idx: got %0d, expected %0d", cmd_idx, e);
        else
          passed++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    btn_in    = '0;
    cmd_ready = 1'b0;
    ovr_clr   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    btn_in    = '0;
    cmd_ready = 1'b0;
    ovr_clr   = 1'b0;
    tick();
    tick();
    checks++;
    if (cmd_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", cmd_valid);
    else passed++;
    checks++;
    if (cmd_idx !== 2'd0) $display("FAIL reset_idx: got %0d, expected 0", cmd_idx);
    else passed++;
    checks++;
    if (pending !== 4'b0000 || busy !== 1'b0)
      $display("FAIL reset_pending: got %b busy %b, expected 0000 busy 0", pending, busy);
    else passed++;
    checks++;
    if (overrun !== 4'b0000) $display("FAIL reset_overrun: got %b, expected 0000", overrun);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    int nv = 0;
    do_reset();
    cmd_ready = 1'b1;
    btn_in    = 4'b0001;
    exp_q.push_back(2'd0);
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (cmd_valid === 1'b1) nv++;
      if (n == 3) begin
        checks++;
        if (pending !== 4'b0001 || cmd_valid !== 1'b0)
          $display("FAIL single_pending_lat: got pending %b valid %b, expected 0001 0", pending, cmd_valid);
        else passed++;
      end
      if (n == 4) begin
        checks++;
        if (cmd_valid !== 1'b1 || cmd_idx !== 2'd0)
          $display("FAIL single_valid_lat: got valid %b idx %0d, expected 1 0", cmd_valid, cmd_idx);
        else passed++;
      end
    end
    checks++;
    if (nv != 1) $display("FAIL single_count: got %0d commands, expected 1", nv);
    else passed++;
    checks++;
    if (pending !== 4'b0000 || busy !== 1'b0)
      $display("FAIL single_idle: got pending %b busy %b, expected 0000 0", pending, busy);
    else passed++;
    btn_in = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [10:1] obs;
    logic [10:1] want;
    do_reset();
    cmd_ready = 1'b1;
    btn_in    = 4'b1101;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    want = '0;
    want[4] = 1'b1;
    want[6] = 1'b1;
    want[8] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      obs[n] = cmd_valid;
    end
    checks++;
    if (obs !== want) $display("FAIL rr_valid_pattern: got %b, expected %b", obs, want);
    else passed++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL rr_drain: got %0d left, expected 0", exp_q.size());
    else passed++;
    btn_in = '0;
    tick();
  endtask

  task automatic test_stall();
    logic stable = 1'b1;
    do_reset();
    btn_in = 4'b0010;
    exp_q.push_back(2'd1);
    for (int n = 1; n <= 4; n++) tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_idx !== 2'd1)
      $display("FAIL stall_offer: got valid %b idx %0d, expected 1 1", cmd_valid, cmd_idx);
    else passed++;
    btn_in = 4'b0000;
    for (int n = 5; n <= 9; n++) begin
      tick();
      if (n == 6) btn_in = 4'b0010;
      if (cmd_valid !== 1'b1 || cmd_idx !== 2'd1) stable = 1'b0;
    end
    checks++;
    if (!stable) $display("FAIL stall_stable: got unstable offer, expected idx 1 held");
    else passed++;
    checks++;
    if (overrun !== 4'b0010) $display("FAIL stall_overrun: got %b, expected 0010", overrun);
    else passed++;
    cmd_ready = 1'b1;
    tick();
    checks++;
    if (pending !== 4'b0000 || cmd_valid !== 1'b0 || overrun !== 4'b0010)
      $display("FAIL stall_after: got pending %b valid %b ovr %b, expected 0000 0 0010",
               pending, cmd_valid, overrun);
    else passed++;
    cmd_ready = 1'b0;
    ovr_clr   = 1'b1;
    tick();
    ovr_clr = 1'b0;
    checks++;
    if (overrun !== 4'b0000) $display("FAIL stall_ovr_clr: got %b, expected 0000", overrun);
    else passed++;
    btn_in = '0;
    tick();
  endtask

  task automatic test_coincide();
    do_reset();
    cmd_ready = 1'b1;
    btn_in    = 4'b0100;
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd2);
    tick();
    btn_in = 4'b0000;
    tick();
    btn_in = 4'b0100;
    tick();
    tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_idx !== 2'd2)
      $display("FAIL coin_first: got valid %b idx %0d, expected 1 2", cmd_valid, cmd_idx);
    else passed++;
    tick();
    checks++;
    if (pending !== 4'b0100 || cmd_valid !== 1'b0 || overrun !== 4'b0000)
      $display("FAIL coin_keep: got pending %b valid %b ovr %b, expected 0100 0 0000",
               pending, cmd_valid, overrun);
    else passed++;
    tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_idx !== 2'd2)
      $display("FAIL coin_second: got valid %b idx %0d, expected 1 2", cmd_valid, cmd_idx);
    else passed++;
    tick();
    checks++;
    if (pending !== 4'b0000 || overrun !== 4'b0000)
      $display("FAIL coin_end: got pending %b ovr %b, expected 0000 0000", pending, overrun);
    else passed++;
    btn_in = '0;
    tick();
  endtask

  task automatic test_reset_offer();
    do_reset();
    btn_in = 4'b1000;
    for (int n = 1; n <= 4; n++) tick();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_idx !== 2'd3)
      $display("FAIL rst_offer: got valid %b idx %0d, expected 1 3", cmd_valid, cmd_idx);
    else passed++;
    #3;
    reset  = 1'b1;
    btn_in = '0;
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || pending !== 4'b0000)
      $display("FAIL rst_async: got valid %b pending %b, expected 0 0000", cmd_valid, pending);
    else passed++;
    tick();
    tick();
    reset = 1'b0;
    tick();
    cmd_ready = 1'b1;
    btn_in    = 4'b1001;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd3);
    wait_drain(20);
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL rst_regrant: got %0d left, expected 0", exp_q.size());
    else passed++;
    btn_in = '0;
    tick();
  endtask

`ifdef BTN_DEBOUNCE_EN
  task automatic test_debounce();
    int first = 0;
    do_reset();
    cmd_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      btn_in = (p % 2 == 0) ? 4'b0001 : 4'b0000;
      for (int c = 0; c < 3; c++) tick();
    end
    btn_in = 4'b0001;
    exp_q.push_back(2'd0);
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (first == 0 && cmd_valid === 1'b1) first = n;
    end
    checks++;
    if (first != 20) $display("FAIL db_latency: got %0d, expected 20", first);
    else passed++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL db_count: got %0d left, expected 0", exp_q.size());
    else passed++;
    btn_in = '0;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    btn_in    = '0;
    cmd_ready = 1'b0;
    ovr_clr   = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_coincide();
    test_reset_offer();
`ifdef BTN_DEBOUNCE_EN
    test_debounce();
`endif
    tick();
    checks++;
    if (exp_q.size() != 0) $display("FAIL final_queue: got %0d left, expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
